// File: rtl/spiel_pkg.sv
// Shared types and constants for the game-state / score logic.
package spiel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVER
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_addierer.sv
// Combinational 4-digit BCD adder: adds 0..10 into the units digit,
// ripples digit carries upward and saturates at 9999.
module bcd_addierer
  import spiel_pkg::*;
(
  input  logic [15:0] summand,
  input  bcd_digit_t  inc,
  output logic [15:0] sum
);

  logic [15:0] sum_raw;
  logic [4:0]  digit_sum;
  logic [4:0]  digit_adj;
  logic        carry;

  // A units digit of 9 plus 10 gives at most 19, so one -10 correction suffices.
  always_comb begin
    sum_raw   = '0;
    digit_sum = '0;
    digit_adj = '0;
    carry     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      digit_sum = {1'b0, summand[4*i +: 4]} + {4'b0, carry}
                + ((i == 0) ? {1'b0, inc} : 5'd0);
      if (digit_sum > 5'd9) begin
        digit_adj          = digit_sum - 5'd10;
        sum_raw[4*i +: 4]  = digit_adj[3:0];
        carry              = 1'b1;
      end else begin
        sum_raw[4*i +: 4]  = digit_sum[3:0];
        carry              = 1'b0;
      end
    end
    sum = carry ? BCD_MAX : sum_raw;
  end

endmodule

// File: rtl/punkte_zaehler.sv
// Game FSM and BCD score counter feeding the score/high-score renderer.
// The score is frozen during game over so the high-score compare sees a constant.
module punkte_zaehler
  import spiel_pkg::*;
#(
  parameter int FRAMES_PER_POINT = 30,
  parameter int BONUS            = 5,
  parameter int HOLD_FRAMES      = 120
) (
  input  logic        clk75MHz,
  input  logic        rst_n,
  input  logic        FrameTick,
  input  logic        Start,
  input  logic        Hindernis,
  input  logic        KollisionIn,
  output logic [15:0] Punkte,
  output logic        Kollision,
  output logic        Laeuft,
  output logic [1:0]  Tempo
);

  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_POINT - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam bcd_digit_t BONUS_BCD  = 4'(BONUS);

  state_t      state;
  logic [7:0]  frame_cnt;
  logic [7:0]  hold_cnt;
  logic        start_prev;
  logic        point_due;
  bcd_digit_t  inc;
  logic [15:0] sum;

  assign point_due = FrameTick && (frame_cnt == FRAME_LAST);
  assign inc       = {3'b000, point_due} + (Hindernis ? BONUS_BCD : 4'd0);
  assign Tempo     = (Punkte[15:12] > 4'd3) ? 2'd3 : Punkte[13:12];

  bcd_addierer u_addierer (
    .summand (Punkte),
    .inc     (inc),
    .sum     (sum)
  );

  always_ff @(posedge clk75MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      hold_cnt   <= '0;
      start_prev <= 1'b0;
      Punkte     <= '0;
      Kollision  <= 1'b0;
      Laeuft     <= 1'b0;
    end else begin
      start_prev <= Start;
      case (state)
        IDLE: begin
          if (Start && !start_prev) begin
            state     <= RUN;
            Punkte    <= '0;
            frame_cnt <= '0;
            hold_cnt  <= '0;
            Laeuft    <= 1'b1;
          end
        end
        RUN: begin
          // Collision wins over any point or bonus sampled in the same cycle.
          if (KollisionIn) begin
            state     <= OVER;
            Laeuft    <= 1'b0;
            Kollision <= 1'b1;
          end else begin
            if (FrameTick) frame_cnt <= point_due ? 8'd0 : frame_cnt + 8'd1;
            if (inc != 4'd0) Punkte <= sum;
          end
        end
        OVER: begin
          if (FrameTick) begin
            if (hold_cnt == HOLD_LAST) begin
              state     <= IDLE;
              Kollision <= 1'b0;
              hold_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_punkte_zaehler.sv
// Directed self-checking bench for punkte_zaehler (FRAMES_PER_POINT=2, BONUS=5, HOLD_FRAMES=4).
module tb_punkte_zaehler;

  logic        clk75MHz;
  logic        rst_n;
  logic        FrameTick;
  logic        Start;
  logic        Hindernis;
  logic        KollisionIn;
  logic [15:0] Punkte;
  logic        Kollision;
  logic        Laeuft;
  logic [1:0]  Tempo;

  int checks = 0;
  int passed = 0;

  punkte_zaehler #(
    .FRAMES_PER_POINT (2),
    .BONUS            (5),
    .HOLD_FRAMES      (4)
  ) dut (
    .clk75MHz    (clk75MHz),
    .rst_n       (rst_n),
    .FrameTick   (FrameTick),
    .Start       (Start),
    .Hindernis   (Hindernis),
    .KollisionIn (KollisionIn),
    .Punkte      (Punkte),
    .Kollision   (Kollision),
    .Laeuft      (Laeuft),
    .Tempo       (Tempo)
  );

  initial clk75MHz = 1'b0;
  always #5 clk75MHz = ~clk75MHz;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk75MHz);
    #1;
  endtask

  task automatic run_hindernis(input int n);
    Hindernis = 1'b1;
    repeat (n) step();
    Hindernis = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    FrameTick = 1'b1;
    repeat (n) step();
    FrameTick = 1'b0;
  endtask

  task automatic new_game();
    KollisionIn = 1'b1;
    step();
    KollisionIn = 1'b0;
    run_ticks(4);
    Start = 1'b0;
    step();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; FrameTick = 1'b0; Start = 1'b0; Hindernis = 1'b0; KollisionIn = 1'b0;
    #22;
    checks++;
    if ({Punkte, Kollision, Laeuft, Tempo} !== 20'h0) begin
      $display("[TB] FAIL reset_outputs: got %h/%b/%b/%0d expected 0000/0/0/0", Punkte, Kollision, Laeuft, Tempo);
    end else passed++;
    @(negedge clk75MHz);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_start_frames();
    Start = 1'b1;
    step();
    Start = 1'b0;
    checks++;
    if (Laeuft !== 1'b1 || Punkte !== 16'h0000) begin
      $display("[TB] FAIL start_edge: got Laeuft=%b Punkte=%h expected 1/0000", Laeuft, Punkte);
    end else passed++;
    run_ticks(1);
    checks++;
    if (Punkte !== 16'h0000) $display("[TB] FAIL first_tick: got %h expected 0000", Punkte);
    else passed++;
    run_ticks(9);
    checks++;
    if (Punkte !== 16'h0005) $display("[TB] FAIL ten_ticks: got %h expected 0005", Punkte);
    else passed++;
  endtask

  task automatic test_bcd_carry();
    run_hindernis(18);
    run_ticks(8);
    checks++;
    if (Punkte !== 16'h0099) $display("[TB] FAIL reach_0099: got %h expected 0099", Punkte);
    else passed++;
    run_hindernis(1);
    checks++;
    if (Punkte !== 16'h0104) $display("[TB] FAIL carry_0104: got %h expected 0104", Punkte);
    else passed++;
  endtask

  task automatic test_combined_add();
    new_game();
    run_hindernis(1);
    run_ticks(5);
    checks++;
    if (Punkte !== 16'h0007) $display("[TB] FAIL reach_0007: got %h expected 0007", Punkte);
    else passed++;
    FrameTick = 1'b1; Hindernis = 1'b1;
    step();
    FrameTick = 1'b0; Hindernis = 1'b0;
    checks++;
    if (Punkte !== 16'h0013) $display("[TB] FAIL combined_0013: got %h expected 0013", Punkte);
    else passed++;
  endtask

  task automatic test_saturation();
    new_game();
    run_hindernis(200);
    checks++;
    if (Punkte !== 16'h1000 || Tempo !== 2'd1) begin
      $display("[TB] FAIL tempo_1000: got %h/%0d expected 1000/1", Punkte, Tempo);
    end else passed++;
    run_hindernis(800);
    checks++;
    if (Punkte !== 16'h5000 || Tempo !== 2'd3) begin
      $display("[TB] FAIL tempo_5000: got %h/%0d expected 5000/3", Punkte, Tempo);
    end else passed++;
    run_hindernis(999);
    run_ticks(4);
    checks++;
    if (Punkte !== 16'h9997) $display("[TB] FAIL reach_9997: got %h expected 9997", Punkte);
    else passed++;
    run_hindernis(1);
    checks++;
    if (Punkte !== 16'h9999) $display("[TB] FAIL sat_9999: got %h expected 9999", Punkte);
    else passed++;
    run_ticks(2);
    checks++;
    if (Punkte !== 16'h9999) $display("[TB] FAIL sat_hold: got %h expected 9999", Punkte);
    else passed++;
    new_game();
    run_hindernis(1999);
    run_ticks(7);
    checks++;
    if (Punkte !== 16'h9998) $display("[TB] FAIL reach_9998: got %h expected 9998", Punkte);
    else passed++;
    FrameTick = 1'b1; Hindernis = 1'b1;
    step();
    FrameTick = 1'b0; Hindernis = 1'b0;
    checks++;
    if (Punkte !== 16'h9999) $display("[TB] FAIL sat_9998_plus6: got %h expected 9999", Punkte);
    else passed++;
  endtask

  task automatic test_collision();
    new_game();
    run_hindernis(8);
    run_ticks(5);
    checks++;
    if (Punkte !== 16'h0042) $display("[TB] FAIL reach_0042: got %h expected 0042", Punkte);
    else passed++;
    FrameTick = 1'b1; KollisionIn = 1'b1;
    step();
    FrameTick = 1'b0; KollisionIn = 1'b0;
    checks++;
    if (Punkte !== 16'h0042 || Kollision !== 1'b1 || Laeuft !== 1'b0) begin
      $display("[TB] FAIL collision_priority: got %h/%b/%b expected 0042/1/0", Punkte, Kollision, Laeuft);
    end else passed++;
    Start = 1'b1;
    step();
    run_hindernis(1);
    run_ticks(3);
    checks++;
    if (Punkte !== 16'h0042 || Kollision !== 1'b1) begin
      $display("[TB] FAIL over_frozen: got %h/%b expected 0042/1", Punkte, Kollision);
    end else passed++;
    run_ticks(1);
    checks++;
    if (Punkte !== 16'h0042 || Kollision !== 1'b0 || Laeuft !== 1'b0) begin
      $display("[TB] FAIL hold_expired: got %h/%b/%b expected 0042/0/0", Punkte, Kollision, Laeuft);
    end else passed++;
    repeat (3) step();
    checks++;
    if (Laeuft !== 1'b0 || Punkte !== 16'h0042) begin
      $display("[TB] FAIL start_held: got Laeuft=%b Punkte=%h expected 0/0042", Laeuft, Punkte);
    end else passed++;
    Start = 1'b0;
    step();
    Start = 1'b1;
    step();
    Start = 1'b0;
    checks++;
    if (Laeuft !== 1'b1 || Punkte !== 16'h0000) begin
      $display("[TB] FAIL restart_edge: got Laeuft=%b Punkte=%h expected 1/0000", Laeuft, Punkte);
    end else passed++;
  endtask

  task automatic test_reset_mid_run();
    run_hindernis(70);
    checks++;
    if (Punkte !== 16'h0350) $display("[TB] FAIL reach_0350: got %h expected 0350", Punkte);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({Punkte, Kollision, Laeuft, Tempo} !== 20'h0) begin
      $display("[TB] FAIL async_reset: got %h/%b/%b/%0d expected 0000/0/0/0", Punkte, Kollision, Laeuft, Tempo);
    end else passed++;
    @(negedge clk75MHz);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_start_frames();
    test_bcd_carry();
    test_combined_add();
    test_saturation();
    test_collision();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
